// File: rtl/load_store_unit.sv
// load_store_unit: handshaked memory port for the multicycle core.
// Accepts one load or store request and issues an aligned bus access with byte
// strobes and lane-shifted store data. Load data is extracted and sign- or
// zero-extended. Misaligned addresses and bus timeouts are reported with the
// one-cycle response pulse.
// Optional feature: define LSU_MISALIGNED_SPLIT_EN to run misaligned accesses
// on the bus, splitting word-crossing ones into two beats.
//
// state   | meaning
// IDLE    | waiting for a request, o_req_ready high
// ACCESS  | first (or only) bus beat, waiting for i_mem_ready or timeout
// ACCESS2 | second beat of a word-crossing access (split build only)
// RESP    | one-cycle completion pulse
module load_store_unit #(
    parameter int XLEN           = 64,
    parameter int ADDR_WIDTH     = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_write,
    input  logic [2:0]            i_func_3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [XLEN-1:0]       i_wdata,
    output logic                  o_resp_valid,
    output logic [XLEN-1:0]       o_rdata,
    output logic                  o_misaligned,
    output logic                  o_bus_err,
    output logic                  o_mem_valid,
    input  logic                  i_mem_ready,
    output logic                  o_mem_write,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [XLEN/8-1:0]     o_mem_strb,
    output logic [XLEN-1:0]       o_mem_wdata,
    input  logic [XLEN-1:0]       i_mem_rdata
);

    localparam int STRB_W = XLEN / 8;
    localparam int OFF_W  = $clog2(STRB_W);

`ifdef LSU_MISALIGNED_SPLIT_EN
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_ACCESS2, S_RESP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;
`endif

    state_t                  state_q, state_d;
    logic [15:0]             cnt_q;
    logic                    write_q;
    logic [2:0]              func3_q;
    logic [OFF_W-1:0]        off_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [STRB_W-1:0]       strb_q;
    logic [XLEN-1:0]         wdata_q;
    logic [XLEN-1:0]         rdata_q;
    logic                    mis_q;
    logic                    err_q;

    logic                    accept;
    logic                    timeout_hit;
    logic                    mis_n;
    logic [STRB_W-1:0]       byte_mask;
    logic [XLEN-1:0]         wdata_m;
    logic [XLEN-1:0]         load_shift;
    int                      nbytes;

`ifdef LSU_MISALIGNED_SPLIT_EN
    logic                    two_q;
    logic [STRB_W-1:0]       strb2_q;
    logic [XLEN-1:0]         wdata2_q;
    logic [XLEN-1:0]         lo_q;
    logic [2*STRB_W-1:0]     strb_w;
    logic [2*XLEN-1:0]       wdata_w;
    logic [2*XLEN-1:0]       merged;
`else
    logic [STRB_W-1:0]       strb_n;
    logic [XLEN-1:0]         wdata_n;
`endif

    // Truncate to the access size, then sign- or zero-extend to XLEN.
    function automatic logic [XLEN-1:0] extend_load(input logic [XLEN-1:0] v,
                                                    input logic [2:0]      f);
        logic [XLEN-1:0] m;
        logic            s;
        int              nb;
        nb = 1 << int'(f[1:0]);
        for (int i = 0; i < XLEN; i++) m[i] = (i < 8 * nb);
        s = v[8*nb-1];
        return f[2] ? (v & m) : ((v & m) | ({XLEN{s}} & ~m));
    endfunction

    assign accept      = i_req_valid && o_req_ready;
    assign timeout_hit = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    // Request decode: size mask, misalignment and lane placement of store data.
    always_comb begin
        nbytes    = 1 << int'(i_func_3[1:0]);
        byte_mask = '0;
        wdata_m   = '0;
        for (int b = 0; b < STRB_W; b++) byte_mask[b] = (b < nbytes);
        for (int i = 0; i < XLEN; i++) wdata_m[i] = i_wdata[i] & byte_mask[i/8];
`ifdef LSU_MISALIGNED_SPLIT_EN
        mis_n   = (i_func_3[1:0] == 2'd3) && (XLEN == 32);
        strb_w  = {{STRB_W{1'b0}}, byte_mask} << i_addr[OFF_W-1:0];
        wdata_w = {{XLEN{1'b0}}, wdata_m} << {i_addr[OFF_W-1:0], 3'b000};
        merged  = ((state_q == S_ACCESS2) ? {i_mem_rdata, lo_q} : {{XLEN{1'b0}}, i_mem_rdata})
                  >> {off_q, 3'b000};
        load_shift = merged[XLEN-1:0];
`else
        mis_n   = ((i_func_3[1:0] == 2'd3) && (XLEN == 32)) ||
                  ((i_addr[OFF_W-1:0] & OFF_W'(nbytes - 1)) != '0);
        strb_n  = byte_mask << i_addr[OFF_W-1:0];
        wdata_n = wdata_m << {i_addr[OFF_W-1:0], 3'b000};
        load_shift = i_mem_rdata >> {off_q, 3'b000};
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (accept) state_d = mis_n ? S_RESP : S_ACCESS;
            S_ACCESS: begin
                if (i_mem_ready) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                    state_d = two_q ? S_ACCESS2 : S_RESP;
`else
                    state_d = S_RESP;
`endif
                end else if (timeout_hit) begin
                    state_d = S_RESP;
                end
            end
`ifdef LSU_MISALIGNED_SPLIT_EN
            S_ACCESS2: if (i_mem_ready || timeout_hit) state_d = S_RESP;
`endif
            S_RESP:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Request capture, beat sequencing, timeout counting and load capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0; write_q <= 1'b0; func3_q <= '0; off_q <= '0;
            addr_q <= '0; strb_q <= '0; wdata_q <= '0; rdata_q <= '0;
            mis_q <= 1'b0; err_q <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
            two_q <= 1'b0; strb2_q <= '0; wdata2_q <= '0; lo_q <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    cnt_q   <= '0;
                    write_q <= i_req_write;
                    func3_q <= i_func_3;
                    off_q   <= i_addr[OFF_W-1:0];
                    addr_q  <= {i_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                    rdata_q <= '0;
                    mis_q   <= mis_n;
                    err_q   <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
                    strb_q   <= strb_w[STRB_W-1:0];
                    wdata_q  <= wdata_w[XLEN-1:0];
                    strb2_q  <= strb_w[2*STRB_W-1:STRB_W];
                    wdata2_q <= wdata_w[2*XLEN-1:XLEN];
                    two_q    <= |strb_w[2*STRB_W-1:STRB_W];
`else
                    strb_q  <= strb_n;
                    wdata_q <= wdata_n;
`endif
                end
                S_ACCESS: begin
                    if (i_mem_ready) begin
`ifdef LSU_MISALIGNED_SPLIT_EN
                        if (two_q) begin
                            lo_q    <= i_mem_rdata;
                            addr_q  <= addr_q + ADDR_WIDTH'(STRB_W);
                            strb_q  <= strb2_q;
                            wdata_q <= wdata2_q;
                            cnt_q   <= '0;
                        end else if (!write_q) begin
                            rdata_q <= extend_load(load_shift, func3_q);
                        end
`else
                        if (!write_q) rdata_q <= extend_load(load_shift, func3_q);
`endif
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        if (timeout_hit) err_q <= 1'b1;
                    end
                end
`ifdef LSU_MISALIGNED_SPLIT_EN
                S_ACCESS2: begin
                    if (i_mem_ready) begin
                        if (!write_q) rdata_q <= extend_load(load_shift, func3_q);
                    end else begin
                        cnt_q <= cnt_q + 16'd1;
                        if (timeout_hit) err_q <= 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // Outputs are gated so nothing but zeros leaves the unit outside its phase.
    always_comb begin
        o_req_ready  = (state_q == S_IDLE) && !rst;
`ifdef LSU_MISALIGNED_SPLIT_EN
        o_mem_valid  = (state_q == S_ACCESS) || (state_q == S_ACCESS2);
`else
        o_mem_valid  = (state_q == S_ACCESS);
`endif
        o_mem_write  = o_mem_valid && write_q;
        o_mem_addr   = o_mem_valid ? addr_q  : '0;
        o_mem_strb   = o_mem_valid ? strb_q  : '0;
        o_mem_wdata  = o_mem_valid ? wdata_q : '0;
        o_resp_valid = (state_q == S_RESP);
        o_rdata      = o_resp_valid ? rdata_q : '0;
        o_misaligned = o_resp_valid && mis_q;
        o_bus_err    = o_resp_valid && err_q;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Parametrised multicycle load/store unit that replaces the fixed-width memory/load-mux path of the multicycle core with a handshaked memory port. It accepts one load or store request from the control FSM and generates an aligned bus access with byte strobes. It extracts and sign/zero-extends load data and reports misalignment and bus timeout. XLEN is generic (32 or 64); the bus data width equals XLEN.

Parameters:
XLEN, 64, data/register width; legal values 32 or 64
ADDR_WIDTH, 64, byte-address width
TIMEOUT_CYCLES, 255, maximum cycles to wait for i_mem_ready; range 1..65535

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
i_req_valid  input  1  request valid
o_req_ready  output  1  unit idle, request accepted on valid&&ready
i_req_write  input  1  1=store, 0=load
i_func_3  input  3  RISC-V funct3: [1:0] size (0=B,1=H,2=W,3=D), [2]=unsigned (loads only)
i_addr  input  ADDR_WIDTH  byte address
i_wdata  input  XLEN  store data, right-aligned
o_resp_valid  output  1  one-cycle completion pulse
o_rdata  output  XLEN  extended load data, valid with o_resp_valid
o_misaligned  output  1  misalignment error, valid with o_resp_valid
o_bus_err  output  1  timeout error, valid with o_resp_valid
o_mem_valid  output  1  bus request
i_mem_ready  input  1  bus accept; read data valid in the same cycle
o_mem_write  output  1  bus write
o_mem_addr  output  ADDR_WIDTH  address with the low log2(XLEN/8) bits cleared
o_mem_strb  output  XLEN/8  byte strobes
o_mem_wdata  output  XLEN  lane-shifted store data
i_mem_rdata  input  XLEN  bus read data

Behaviour:
- Reset (rst=1 at an edge): state IDLE, timeout counter 0. All outputs 0, including o_req_ready. Reset overrides an access in flight: o_mem_valid drops after that edge and no response is issued.
- o_req_ready=1 only in IDLE with rst=0. The request is captured on the edge where i_req_valid&&o_req_ready.
- Size bytes = 1<<i_func_3[1:0]. Size 3 with XLEN=32 is flagged misaligned. funct3[2]=1 on a store is ignored.
- Misaligned when addr mod size != 0. IDLE -> RESP with o_misaligned=1, o_rdata=0, no bus access.
- Aligned: IDLE -> ACCESS. In ACCESS, o_mem_valid=1 and addr/strb/wdata/write are stable until i_mem_ready.
  - offset = addr mod (XLEN/8)
  - strb = ((1<<size)-1) << offset
  - wdata = i_wdata << (8*offset); bytes outside the strobes are don't-care, driven 0
- ACCESS with i_mem_ready=1: capture i_mem_rdata. Go to RESP.
- Load extraction: rdata >> (8*offset), truncated to size, then sign-extended (funct3[2]=0) or zero-extended (funct3[2]=1) to XLEN. Stores return o_rdata=0.
- Timeout: the counter increments each ACCESS cycle without ready. When it reaches TIMEOUT_CYCLES, go ACCESS -> RESP with o_bus_err=1, o_rdata=0, and o_mem_valid drops.
- RESP: o_resp_valid=1 for exactly one cycle, then IDLE. Error flags and o_rdata are 0 whenever o_resp_valid=0.
- Latency:
  - handshake at edge T, zero-wait memory -> o_mem_valid during cycle T..T+1, o_resp_valid during T+1..T+2
  - misaligned -> o_resp_valid during T..T+1
- Back-to-back requests: the next request can be accepted at the first IDLE cycle after RESP.

Optional Feature:
Macro LSU_MISALIGNED_SPLIT_EN.
- Defined:
  - Misaligned accesses whose bytes lie within one XLEN/8 word run as a single beat with the shifted strobe.
  - Accesses crossing the word boundary run as two beats (ACCESS then ACCESS2): beat 1 covers the low word, beat 2 covers word address+XLEN/8 with the remaining strobes and data.
  - Load bytes are merged before extension. Timeout applies per beat; a timeout on beat 2 reports o_bus_err (the beat-1 store is not rolled back).
  - Size 3 with XLEN=32 is still flagged misaligned.
- Undefined: any misalignment -> o_misaligned as above. No ACCESS2 state.

Test Plan:
1. XLEN=64, LB addr 0x1003, i_mem_rdata=0x0000_0000_8000_0000, ready on first cycle -> o_mem_addr=0x1000, strb=0x08, o_rdata=0xFFFF_FFFF_FFFF_FF80. Same with LBU -> 0x80; resp one cycle after bus handshake.
2. SH addr 0x2006, i_wdata=0x1234 -> o_mem_addr=0x2000, strb=0xC0, o_mem_wdata[63:48]=0x1234, o_mem_write=1, o_resp_valid with o_rdata=0.
3. Macro undefined, LW addr 0x1002 -> o_mem_valid never asserted, o_resp_valid and o_misaligned=1 the cycle after acceptance.
4. TIMEOUT_CYCLES=16, i_mem_ready held 0 -> o_mem_valid high 16 cycles then 0, o_bus_err=1 with o_resp_valid, o_req_ready=1 next cycle.
5. Macro defined, LD addr 0x1004, beat 1 rdata=0x89AB_CDEF_0000_0000, beat 2 rdata=0x0000_0000_0123_4567 -> addresses 0x1000 then 0x1008, strbs 0xF0 then 0x0F, o_rdata=0x0123_4567_89AB_CDEF.
6. rst asserted during ACCESS -> o_mem_valid=0 and o_req_ready=0 next cycle, no o_resp_valid. After release, o_req_ready=1 and a new LW completes normally.
